// File: rtl/ysyx_25060170_wbq.sv
// Writeback queue: in-order commit FIFO with trap/irq redirect and fwd.
// Ports: in_* push side, cmt_* commit side, wb_* regfile write, fwd_*
// lookup (only with YSYX_25060170_WB_FWD_EN), irq_*, ie_jump* redirect.
module ysyx_25060170_wbq #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [1:0]        in_wb_sel,
   input  logic              in_rd_ena,
   input  logic [4:0]        in_rd_addr,
   input  logic [DATA_W-1:0] in_ls_data,
   input  logic [DATA_W-1:0] in_exu_res,
   input  logic [DATA_W-1:0] in_csr_data,
   input  logic              in_trap,
   input  logic [DATA_W-1:0] in_trap_pc,
   input  logic              irq_valid,
   input  logic [DATA_W-1:0] irq_pc,
   output logic              irq_ack,
   output logic              cmt_valid,
   input  logic              cmt_ready,
   output logic [DATA_W-1:0] cmt_pc,
   output logic              wb_rd_ena,
   output logic [4:0]        wb_rd_addr,
   output logic [DATA_W-1:0] wb_data,
   input  logic [4:0]        fwd_addr,
   output logic              fwd_hit,
   output logic [DATA_W-1:0] fwd_data,
   output logic              ie_jump,
   output logic [DATA_W-1:0] ie_jump_pc
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

   logic [DATA_W-1:0] pc_q      [DEPTH];
   logic              rd_ena_q  [DEPTH];
   logic [4:0]        rd_addr_q [DEPTH];
   logic [DATA_W-1:0] data_q    [DEPTH];
   logic              trap_q    [DEPTH];
   logic [DATA_W-1:0] trap_pc_q [DEPTH];

   logic [PTR_W-1:0]  rptr_q, rptr_d;
   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [PTR_W:0]    count_q, count_d;
   logic              ie_jump_q, ie_jump_d;
   logic [DATA_W-1:0] ie_jump_pc_q, ie_jump_pc_d;

   logic              count_nz, head_trap, irq_take;
   logic              pop, push, trap_pop, flush, wb_we;
   logic [DATA_W-1:0] wdata;

   assign count_nz  = (count_q != '0);
   assign head_trap = trap_q[rptr_q];
   // A trap at the head must commit first; irq waits behind it.
   assign irq_take  = irq_valid & count_nz & ~head_trap;
   assign cmt_valid = count_nz & ~irq_take;
   assign pop       = cmt_valid & cmt_ready;
   assign trap_pop  = pop & head_trap;
   assign flush     = trap_pop | irq_take;
   assign in_ready  = (count_q < FULL) & ~ie_jump_q & ~flush;
   assign push      = in_valid & in_ready;
   assign irq_ack   = irq_take;
   assign cmt_pc    = pc_q[rptr_q];

   assign wb_we      = pop & rd_ena_q[rptr_q] & (rd_addr_q[rptr_q] != 5'd0);
   assign wb_rd_ena  = wb_we;
   assign wb_rd_addr = wb_we ? rd_addr_q[rptr_q] : 5'd0;
   assign wb_data    = wb_we ? data_q[rptr_q] : '0;

   assign ie_jump    = ie_jump_q;
   assign ie_jump_pc = ie_jump_pc_q;

   always_comb begin
      wdata = '0;
      unique case (in_wb_sel)
         2'b01:   wdata = in_ls_data;
         2'b10:   wdata = in_exu_res;
         2'b11:   wdata = in_csr_data;
         default: wdata = '0;
      endcase
   end

   always_comb begin
      rptr_d       = rptr_q;
      wptr_d       = wptr_q;
      count_d      = count_q;
      ie_jump_d    = flush;
      ie_jump_pc_d = '0;
      if (irq_take)
         ie_jump_pc_d = irq_pc;
      else if (trap_pop)
         ie_jump_pc_d = trap_pc_q[rptr_q];
      if (flush) begin
         rptr_d  = '0;
         wptr_d  = '0;
         count_d = '0;
      end else begin
         if (push)
            wptr_d = wptr_q + PTR_W'(1);
         if (pop)
            rptr_d = rptr_q + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rptr_q       <= '0;
         wptr_q       <= '0;
         count_q      <= '0;
         ie_jump_q    <= 1'b0;
         ie_jump_pc_q <= '0;
      end else begin
         rptr_q       <= rptr_d;
         wptr_q       <= wptr_d;
         count_q      <= count_d;
         ie_jump_q    <= ie_jump_d;
         ie_jump_pc_q <= ie_jump_pc_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]      <= '0;
            rd_ena_q[i]  <= 1'b0;
            rd_addr_q[i] <= 5'd0;
            data_q[i]    <= '0;
            trap_q[i]    <= 1'b0;
            trap_pc_q[i] <= '0;
         end
      end else if (push) begin
         pc_q[wptr_q]      <= in_pc;
         rd_ena_q[wptr_q]  <= in_rd_ena;
         rd_addr_q[wptr_q] <= in_rd_addr;
         data_q[wptr_q]    <= wdata;
         trap_q[wptr_q]    <= in_trap;
         trap_pc_q[wptr_q] <= in_trap_pc;
      end
   end

`ifdef YSYX_25060170_WB_FWD_EN
   logic [PTR_W-1:0] fidx;
   // Walk oldest to youngest so the last match wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      fidx     = rptr_q;
      for (int i = 0; i < DEPTH; i++) begin
         fidx = rptr_q + PTR_W'(i);
         if (((PTR_W+1)'(i) < count_q) && rd_ena_q[fidx] &&
             (rd_addr_q[fidx] == fwd_addr) && (fwd_addr != 5'd0)) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[fidx];
         end
      end
   end
`else
   logic fwd_unused;
   assign fwd_unused = ^fwd_addr;
   assign fwd_hit    = 1'b0;
   assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_ysyx_25060170_wbq.sv
// Directed bench for ysyx_25060170_wbq.
// Vector table for single entries plus multi-cycle sequences.
module tb_ysyx_25060170_wbq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [31:0] in_pc;
   logic [1:0]  in_wb_sel;
   logic        in_rd_ena;
   logic [4:0]  in_rd_addr;
   logic [31:0] in_ls_data, in_exu_res, in_csr_data;
   logic        in_trap;
   logic [31:0] in_trap_pc;
   logic        irq_valid;
   logic [31:0] irq_pc;
   logic        irq_ack;
   logic        cmt_valid, cmt_ready;
   logic [31:0] cmt_pc;
   logic        wb_rd_ena;
   logic [4:0]  wb_rd_addr;
   logic [31:0] wb_data;
   logic [4:0]  fwd_addr;
   logic        fwd_hit;
   logic [31:0] fwd_data;
   logic        ie_jump;
   logic [31:0] ie_jump_pc;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ysyx_25060170_wbq #(.DATA_W(32), .DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_wb_sel(in_wb_sel),
      .in_rd_ena(in_rd_ena), .in_rd_addr(in_rd_addr),
      .in_ls_data(in_ls_data), .in_exu_res(in_exu_res),
      .in_csr_data(in_csr_data),
      .in_trap(in_trap), .in_trap_pc(in_trap_pc),
      .irq_valid(irq_valid), .irq_pc(irq_pc), .irq_ack(irq_ack),
      .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_pc(cmt_pc),
      .wb_rd_ena(wb_rd_ena), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
      .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
      .ie_jump(ie_jump), .ie_jump_pc(ie_jump_pc)
   );

   typedef struct {
      logic [1:0]  sel;
      logic        ena;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [31:0] ls;
      logic [31:0] exu;
      logic [31:0] csr;
      logic        x_ena;
      logic [4:0]  x_addr;
      logic [31:0] x_data;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_e(input logic ena, input logic [4:0] rd,
                         input logic [31:0] d, input logic trap,
                         input logic [31:0] tpc);
      in_valid   = 1'b1;
      in_wb_sel  = 2'b10;
      in_rd_ena  = ena;
      in_rd_addr = rd;
      in_exu_res = d;
      in_pc      = 32'h8000_0000 + {27'd0, rd};
      in_trap    = trap;
      in_trap_pc = tpc;
      tick();
      in_valid   = 1'b0;
      in_trap    = 1'b0;
      #1;
   endtask

   initial begin
      vecs[0] = '{2'b00, 1'b1, 5'd3,  32'h1000, 32'h1, 32'h2, 32'h3,
                  1'b1, 5'd3,  32'h0};
      vecs[1] = '{2'b01, 1'b1, 5'd9,  32'h1004, 32'hAAAA, 32'h2, 32'h3,
                  1'b1, 5'd9,  32'hAAAA};
      vecs[2] = '{2'b10, 1'b1, 5'd1,  32'h1008, 32'h1, 32'hBEEF, 32'h3,
                  1'b1, 5'd1,  32'hBEEF};
      vecs[3] = '{2'b11, 1'b1, 5'd31, 32'h100C, 32'h1, 32'h2, 32'hC5C5,
                  1'b1, 5'd31, 32'hC5C5};
      vecs[4] = '{2'b10, 1'b1, 5'd0,  32'h1010, 32'h1, 32'hFF, 32'h3,
                  1'b0, 5'd0,  32'h0};
      vecs[5] = '{2'b10, 1'b0, 5'd5,  32'h1014, 32'h1, 32'h77, 32'h3,
                  1'b0, 5'd0,  32'h0};

      rst = 1'b0;
      in_valid = 0; in_pc = 0; in_wb_sel = 0; in_rd_ena = 0;
      in_rd_addr = 0; in_ls_data = 0; in_exu_res = 0; in_csr_data = 0;
      in_trap = 0; in_trap_pc = 0; irq_valid = 0; irq_pc = 0;
      cmt_ready = 0; fwd_addr = 0;
      #12;
      check("rst_cmt_valid", {31'd0, cmt_valid}, 32'd0);
      check("rst_wb_ena", {31'd0, wb_rd_ena}, 32'd0);
      check("rst_ie_jump", {31'd0, ie_jump}, 32'd0);
      check("rst_irq_ack", {31'd0, irq_ack}, 32'd0);
      rst = 1'b1;
      tick();
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_fwd_hit", {31'd0, fwd_hit}, 32'd0);

      // Single-entry vectors: select mux and rd gating.
      for (int i = 0; i < 6; i++) begin
         in_valid    = 1'b1;
         in_wb_sel   = vecs[i].sel;
         in_rd_ena   = vecs[i].ena;
         in_rd_addr  = vecs[i].rd;
         in_pc       = vecs[i].pc;
         in_ls_data  = vecs[i].ls;
         in_exu_res  = vecs[i].exu;
         in_csr_data = vecs[i].csr;
         tick();
         in_valid = 1'b0;
         #1;
         check($sformatf("v%0d_cmt_valid", i), {31'd0, cmt_valid}, 32'd1);
         check($sformatf("v%0d_cmt_pc", i), cmt_pc, vecs[i].pc);
         check($sformatf("v%0d_hold", i), {31'd0, wb_rd_ena}, 32'd0);
         cmt_ready = 1'b1;
         #1;
         check($sformatf("v%0d_wb_ena", i), {31'd0, wb_rd_ena},
               {31'd0, vecs[i].x_ena});
         check($sformatf("v%0d_wb_addr", i), {27'd0, wb_rd_addr},
               {27'd0, vecs[i].x_addr});
         check($sformatf("v%0d_wb_data", i), wb_data, vecs[i].x_data);
         tick();
         cmt_ready = 1'b0;
         #1;
         check($sformatf("v%0d_empty", i), {31'd0, cmt_valid}, 32'd0);
      end

      // Fill to full, then drain in order.
      for (int i = 1; i <= 4; i++) begin
         #1;
         check($sformatf("fill%0d_rdy", i), {31'd0, in_ready}, 32'd1);
         push_e(1'b1, 5'(i), 32'h11 * i, 1'b0, 32'h0);
      end
      check("full_in_ready", {31'd0, in_ready}, 32'd0);
      cmt_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         #1;
         check($sformatf("drain%0d_ena", i), {31'd0, wb_rd_ena}, 32'd1);
         check($sformatf("drain%0d_addr", i), {27'd0, wb_rd_addr}, i);
         check($sformatf("drain%0d_data", i), wb_data, 32'h11 * i);
         tick();
      end
      cmt_ready = 1'b0;
      #1;
      check("drained_empty", {31'd0, cmt_valid}, 32'd0);

      // Forwarding: youngest match wins.
      push_e(1'b1, 5'd7, 32'h10, 1'b0, 32'h0);
      push_e(1'b1, 5'd7, 32'h20, 1'b0, 32'h0);
      fwd_addr = 5'd7;
      #1;
`ifdef YSYX_25060170_WB_FWD_EN
      check("fwd7_hit", {31'd0, fwd_hit}, 32'd1);
      check("fwd7_data", fwd_data, 32'h20);
`else
      check("fwd7_hit", {31'd0, fwd_hit}, 32'd0);
      check("fwd7_data", fwd_data, 32'h0);
`endif
      fwd_addr = 5'd0;
      #1;
      check("fwd0_hit", {31'd0, fwd_hit}, 32'd0);
      cmt_ready = 1'b1;
      tick();
      tick();
      cmt_ready = 1'b0;
      #1;
      check("fwd_drained", {31'd0, cmt_valid}, 32'd0);

      // Trap commit flushes younger entries and redirects once.
      push_e(1'b1, 5'd5, 32'h1, 1'b0, 32'h0);
      push_e(1'b0, 5'd0, 32'h0, 1'b1, 32'h8000_0100);
      push_e(1'b1, 5'd6, 32'h66, 1'b0, 32'h0);
      cmt_ready = 1'b1;
      #1;
      check("trapA_addr", {27'd0, wb_rd_addr}, 32'd5);
      check("trapA_data", wb_data, 32'h1);
      tick();
      in_valid = 1'b1;
      in_rd_ena = 1'b1;
      in_rd_addr = 5'd8;
      #1;
      check("trapB_valid", {31'd0, cmt_valid}, 32'd1);
      check("trapB_in_ready", {31'd0, in_ready}, 32'd0);
      check("trapB_nojump", {31'd0, ie_jump}, 32'd0);
      tick();
      in_valid = 1'b0;
      #1;
      check("trap_jump", {31'd0, ie_jump}, 32'd1);
      check("trap_jump_pc", ie_jump_pc, 32'h8000_0100);
      check("trap_flushed", {31'd0, cmt_valid}, 32'd0);
      check("trap_jmp_rdy", {31'd0, in_ready}, 32'd0);
      tick();
      check("trap_jump_off", {31'd0, ie_jump}, 32'd0);
      check("trap_pc_off", ie_jump_pc, 32'h0);
      check("trap_still_empty", {31'd0, cmt_valid}, 32'd0);
      cmt_ready = 1'b0;

      // Interrupt taken with two entries queued.
      push_e(1'b1, 5'd2, 32'h22, 1'b0, 32'h0);
      push_e(1'b1, 5'd3, 32'h33, 1'b0, 32'h0);
      irq_valid = 1'b1;
      irq_pc = 32'h8000_0200;
      cmt_ready = 1'b1;
      #1;
      check("irq_ack", {31'd0, irq_ack}, 32'd1);
      check("irq_no_cmt", {31'd0, cmt_valid}, 32'd0);
      check("irq_no_wb", {31'd0, wb_rd_ena}, 32'd0);
      tick();
      irq_valid = 1'b0;
      irq_pc = 32'hDEAD_0000;
      #1;
      check("irq_jump", {31'd0, ie_jump}, 32'd1);
      check("irq_jump_pc", ie_jump_pc, 32'h8000_0200);
      check("irq_empty", {31'd0, cmt_valid}, 32'd0);
      tick();
      check("irq_jump_off", {31'd0, ie_jump}, 32'd0);
      cmt_ready = 1'b0;

      // Interrupt deferred behind a trap head.
      push_e(1'b0, 5'd0, 32'h0, 1'b1, 32'h8000_0300);
      irq_valid = 1'b1;
      irq_pc = 32'h8000_0400;
      #1;
      check("defer_no_ack", {31'd0, irq_ack}, 32'd0);
      check("defer_cmt", {31'd0, cmt_valid}, 32'd1);
      cmt_ready = 1'b1;
      tick();
      check("defer_jump", {31'd0, ie_jump}, 32'd1);
      check("defer_jump_pc", ie_jump_pc, 32'h8000_0300);
      irq_valid = 1'b0;
      cmt_ready = 1'b0;
      tick();

      // Asynchronous reset with entries queued.
      push_e(1'b1, 5'd1, 32'h1, 1'b0, 32'h0);
      push_e(1'b1, 5'd2, 32'h2, 1'b0, 32'h0);
      push_e(1'b1, 5'd3, 32'h3, 1'b0, 32'h0);
      #1;
      rst = 1'b0;
      #1;
      check("arst_cmt_valid", {31'd0, cmt_valid}, 32'd0);
      check("arst_wb_ena", {31'd0, wb_rd_ena}, 32'd0);
      #2;
      rst = 1'b1;
      tick();
      check("arst_rel_valid", {31'd0, cmt_valid}, 32'd0);
      check("arst_rel_rdy", {31'd0, in_ready}, 32'd1);

      // Asynchronous reset while a redirect is pending.
      push_e(1'b0, 5'd0, 32'h0, 1'b1, 32'h8000_0500);
      cmt_ready = 1'b1;
      tick();
      cmt_ready = 1'b0;
      check("arst_pre_jump", {31'd0, ie_jump}, 32'd1);
      rst = 1'b0;
      #1;
      check("arst_jump", {31'd0, ie_jump}, 32'd0);
      check("arst_jump_pc", ie_jump_pc, 32'h0);
      #2;
      rst = 1'b1;
      tick();
      check("arst_no_jump", {31'd0, ie_jump}, 32'd0);
      check("arst_final_rdy", {31'd0, in_ready}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
